// File: rtl/ex_mem_flag_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_stage
//
// EX/MEM boundary register plus the architectural Z/V/N flag register.
// Sits directly behind the ALU (adders, shifters, RED reduction unit) and
// captures the ALU result and destination info one cycle after EX. The flags
// are updated per opcode class and are exported registered to the branch unit.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous reset, active low (overrides stall/flush)
//   in_valid      in   ALU output belongs to a real instruction
//   stall         in   hold the whole stage, flags included
//   flush         in   kill the instruction entering this stage
//   opcode        in   [3:0] opcode of the instruction in EX
//   alu_result    in   [DW-1:0] ALU output (RED already sign-extended)
//   alu_ovfl      in   signed overflow from the ADD/SUB adder
//   rd            in   [RW-1:0] destination register
//   reg_write     in   instruction writes rd
//   out_valid     out  registered valid
//   out_result    out  [DW-1:0] registered ALU result
//   out_rd        out  [RW-1:0] registered rd
//   out_reg_write out  registered write enable, 0 whenever out_valid is 0
//   flag_z        out  zero flag
//   flag_v        out  overflow flag
//   flag_n        out  negative flag
// ---------------------------------------------------------------------------
module ex_mem_flag_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovfl,
    input  logic [RW-1:0] rd,
    input  logic          reg_write,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);

    // Per-flag action; each flag is independently held or loaded.
    typedef enum logic {
        FLAG_HOLD = 1'b0,
        FLAG_LOAD = 1'b1
    } flag_act_t;

    localparam int NF  = 3;
    localparam int F_Z = 0;
    localparam int F_V = 1;
    localparam int F_N = 2;

    logic            w_cap;
    logic            w_cls_zvn;   // ADD/SUB: full Z/V/N update
    logic            w_cls_z;     // XOR/shifts: Z only
    logic [NF-1:0]   w_flag_val;
    flag_act_t       w_flag_act [NF];

    logic            r_valid;
    logic [DW-1:0]   r_result;
    logic [RW-1:0]   r_rd;
    logic            r_reg_write;
    logic [NF-1:0]   r_flags;

    assign w_cap = in_valid & ~stall & ~flush;

    // Opcode classification. 1xxx ops, RED and PADDSB fall into neither
    // class and therefore never touch the flags.
    always_comb begin
        w_cls_zvn = 1'b0;
        w_cls_z   = 1'b0;
        case (opcode)
            4'b0000, 4'b0001:                   w_cls_zvn = 1'b1;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: w_cls_z   = 1'b1;
            default: ;
        endcase
    end

    assign w_flag_val[F_Z] = (alu_result == '0);
    assign w_flag_val[F_V] = alu_ovfl;
    assign w_flag_val[F_N] = alu_result[DW-1];

    // Next-action selection for each flag.
    always_comb begin
        for (int i = 0; i < NF; i++) begin
            w_flag_act[i] = FLAG_HOLD;
        end
        if (w_cap) begin
            if (w_cls_zvn) begin
                w_flag_act[F_Z] = FLAG_LOAD;
                w_flag_act[F_V] = FLAG_LOAD;
                w_flag_act[F_N] = FLAG_LOAD;
            end else if (w_cls_z) begin
                w_flag_act[F_Z] = FLAG_LOAD;
            end
        end
    end

    // Boundary register: reset > flush > stall > normal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            // Data fields are left as they were; valid and write-enable die.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (stall) begin
            r_valid     <= r_valid;
            r_reg_write <= r_reg_write;
        end else if (in_valid) begin
            r_valid     <= 1'b1;
            r_result    <= alu_result;
            r_rd        <= rd;
            r_reg_write <= reg_write;
        end else begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
    end

    // Flag registers. Stall and flush both clear w_cap, so they hold here.
    generate
        for (genvar gi = 0; gi < NF; gi++) begin : g_flag
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_flags[gi] <= 1'b0;
                end else if (w_flag_act[gi] == FLAG_LOAD) begin
                    r_flags[gi] <= w_flag_val[gi];
                end
            end
        end
    endgenerate

    assign out_valid     = r_valid;
    assign out_result    = r_result;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write;
    assign flag_z        = r_flags[F_Z];
    assign flag_v        = r_flags[F_V];
    assign flag_n        = r_flags[F_N];

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_flag_stage
//
// Bench for ex_mem_flag_stage: a directed vector table (reset, flag classes,
// stall/flush, bubbles, reset during stall) followed by randomized cycles
// checked against an architectural model of the stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_flag_stage;

    localparam int DW = 16;
    localparam int RW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          stall;
    logic          flush;
    logic [3:0]    opcode;
    logic [DW-1:0] alu_result;
    logic          alu_ovfl;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_reg_write;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_flag_stage #(.DW(DW), .RW(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .opcode       (opcode),
        .alu_result   (alu_result),
        .alu_ovfl     (alu_ovfl),
        .rd           (rd),
        .reg_write    (reg_write),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_n       (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          iv;
        logic          st;
        logic          fl;
        logic [3:0]    op;
        logic [DW-1:0] res;
        logic          ovfl;
        logic [RW-1:0] rd;
        logic          rw;
        logic          chk_data;   // result/rd are defined after this edge
        logic          e_valid;
        logic [DW-1:0] e_res;
        logic [RW-1:0] e_rd;
        logic          e_rw;
        logic          e_z;
        logic          e_v;
        logic          e_n;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic rst_n_i, input logic iv, input logic st, input logic fl,
        input logic [3:0] op, input logic [DW-1:0] res, input logic ovfl,
        input logic [RW-1:0] rd_i, input logic rw, input logic chk,
        input logic ev, input logic [DW-1:0] eres, input logic [RW-1:0] erd,
        input logic erw, input logic ez, input logic evf, input logic en);
        vec_t v;
        v.rst_n = rst_n_i; v.iv = iv; v.st = st; v.fl = fl; v.op = op;
        v.res = res; v.ovfl = ovfl; v.rd = rd_i; v.rw = rw; v.chk_data = chk;
        v.e_valid = ev; v.e_res = eres; v.e_rd = erd; v.e_rw = erw;
        v.e_z = ez; v.e_v = evf; v.e_n = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic st, input logic fl,
                         input logic [3:0] op, input logic [DW-1:0] res, input logic ov,
                         input logic [RW-1:0] d, input logic rw);
        rst_n = r; in_valid = iv; stall = st; flush = fl; opcode = op;
        alu_result = res; alu_ovfl = ov; rd = d; reg_write = rw;
        @(posedge clk);
        #1;
    endtask

    // Architectural model state
    logic          m_valid;
    logic [DW-1:0] m_res;
    logic [RW-1:0] m_rd;
    logic          m_rw;
    logic          m_z, m_v, m_n;

    // Model of one clock edge, straight from the stage's rules.
    task automatic model_edge(input logic r, input logic iv, input logic st, input logic fl,
                              input logic [3:0] op, input logic [DW-1:0] res, input logic ov,
                              input logic [RW-1:0] d, input logic rw);
        if (!r) begin
            m_valid = 0; m_res = 0; m_rd = 0; m_rw = 0; m_z = 0; m_v = 0; m_n = 0;
        end else if (fl) begin
            m_valid = 0; m_rw = 0;
        end else if (st) begin
            // everything holds
        end else if (!iv) begin
            m_valid = 0; m_rw = 0;
        end else begin
            m_valid = 1; m_res = res; m_rd = d; m_rw = rw;
            if (op == 4'd0 || op == 4'd1) begin
                m_z = (res == 0); m_v = ov; m_n = res[DW-1];
            end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
                m_z = (res == 0);
            end
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; stall = 0; flush = 0; opcode = 0;
        alu_result = 0; alu_ovfl = 0; rd = 0; reg_write = 0;

        //          rst iv st fl op     res       ov rd  rw chk  ev eres      erd erw z  v  n
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 16'h0000, 0, 4'h2, 1, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // reset 1
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 16'h0000, 0, 4'h2, 1, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // reset 2
        vecs.push_back(mk(1, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // idle after reset
        vecs.push_back(mk(1, 1, 0, 0, 4'h0, 16'h8000, 1, 4'h3, 1, 1, 1, 16'h8000, 4'h3, 1, 0, 1, 1)); // ADD
        vecs.push_back(mk(1, 1, 0, 0, 4'h2, 16'h0000, 0, 4'h4, 1, 1, 1, 16'h0000, 4'h4, 1, 1, 1, 1)); // XOR Z only
        vecs.push_back(mk(1, 1, 0, 0, 4'h3, 16'hFFC4, 0, 4'h5, 1, 1, 1, 16'hFFC4, 4'h5, 1, 1, 1, 1)); // RED
        vecs.push_back(mk(1, 1, 1, 0, 4'h0, 16'h0001, 0, 4'h6, 1, 1, 1, 16'hFFC4, 4'h5, 1, 1, 1, 1)); // stall 1
        vecs.push_back(mk(1, 1, 1, 0, 4'h0, 16'h0001, 0, 4'h6, 1, 1, 1, 16'hFFC4, 4'h5, 1, 1, 1, 1)); // stall 2
        vecs.push_back(mk(1, 1, 1, 0, 4'h0, 16'h0001, 0, 4'h6, 1, 1, 1, 16'hFFC4, 4'h5, 1, 1, 1, 1)); // stall 3
        vecs.push_back(mk(1, 1, 1, 1, 4'h0, 16'h0001, 0, 4'h6, 1, 0, 0, 16'h0000, 4'h0, 0, 1, 1, 1)); // stall+flush
        vecs.push_back(mk(1, 1, 0, 0, 4'h0, 16'h0001, 0, 4'h6, 1, 1, 1, 16'h0001, 4'h6, 1, 0, 0, 0)); // ADD after
        vecs.push_back(mk(1, 0, 0, 0, 4'h0, 16'h0000, 1, 4'h7, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // bubble
        vecs.push_back(mk(1, 1, 0, 0, 4'h1, 16'h7FFF, 1, 4'h8, 1, 1, 1, 16'h7FFF, 4'h8, 1, 0, 1, 0)); // SUB
        vecs.push_back(mk(1, 1, 0, 0, 4'h4, 16'h8000, 0, 4'h9, 1, 1, 1, 16'h8000, 4'h9, 1, 0, 1, 0)); // SLL: N holds
        vecs.push_back(mk(1, 1, 0, 0, 4'h7, 16'h0000, 1, 4'hA, 0, 1, 1, 16'h0000, 4'hA, 0, 0, 1, 0)); // PADDSB
        vecs.push_back(mk(1, 1, 0, 0, 4'hA, 16'h0000, 0, 4'hB, 0, 1, 1, 16'h0000, 4'hB, 0, 0, 1, 0)); // mem op
        vecs.push_back(mk(1, 1, 0, 0, 4'h5, 16'h0000, 0, 4'hC, 1, 1, 1, 16'h0000, 4'hC, 1, 1, 1, 0)); // SRA
        vecs.push_back(mk(1, 1, 0, 0, 4'h6, 16'h0005, 0, 4'hD, 1, 1, 1, 16'h0005, 4'hD, 1, 0, 1, 0)); // ROR
        vecs.push_back(mk(1, 1, 1, 0, 4'h0, 16'h8000, 1, 4'hE, 1, 1, 1, 16'h0005, 4'hD, 1, 0, 1, 0)); // stall
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 16'h8000, 1, 4'hE, 1, 1, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // reset mid-stall
        vecs.push_back(mk(1, 1, 0, 1, 4'h0, 16'h8000, 1, 4'hE, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 0, 0)); // flush only
        vecs.push_back(mk(1, 1, 0, 0, 4'h0, 16'hFFFF, 0, 4'h1, 1, 1, 1, 16'hFFFF, 4'h1, 1, 0, 0, 1)); // ADD b2b 1
        vecs.push_back(mk(1, 1, 0, 0, 4'h1, 16'h0000, 1, 4'h2, 0, 1, 1, 16'h0000, 4'h2, 0, 1, 1, 0)); // SUB b2b 2

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst_n, v.iv, v.st, v.fl, v.op, v.res, v.ovfl, v.rd, v.rw);
            $display("vec %0d: rst_n=%b iv=%b st=%b fl=%b op=%h res=%h -> valid=%b res=%h rd=%h rw=%b zvn=%b%b%b",
                     i, v.rst_n, v.iv, v.st, v.fl, v.op, v.res,
                     out_valid, out_result, out_rd, out_reg_write, flag_z, flag_v, flag_n);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v.e_valid));
            chk($sformatf("vec%0d out_reg_write", i), 32'(out_reg_write), 32'(v.e_rw));
            chk($sformatf("vec%0d flag_z", i), 32'(flag_z), 32'(v.e_z));
            chk($sformatf("vec%0d flag_v", i), 32'(flag_v), 32'(v.e_v));
            chk($sformatf("vec%0d flag_n", i), 32'(flag_n), 32'(v.e_n));
            if (v.chk_data) begin
                chk($sformatf("vec%0d out_result", i), 32'(out_result), 32'(v.e_res));
                chk($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(v.e_rd));
            end
        end

        // Randomized phase; first cycle is a reset so model and DUT align.
        m_valid = 0; m_res = 0; m_rd = 0; m_rw = 0; m_z = 0; m_v = 0; m_n = 0;
        for (int c = 0; c < 600; c++) begin
            logic          r, iv, st, fl, ov, rw;
            logic [3:0]    op;
            logic [DW-1:0] res;
            logic [RW-1:0] d;
            r   = (c == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            op  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       res = '0;
                1:       res = 16'h8000 | 16'($urandom_range(0, 65535));
                default: res = 16'($urandom_range(0, 65535));
            endcase
            ov  = 1'($urandom_range(0, 1));
            d   = 4'($urandom_range(0, 15));
            rw  = 1'($urandom_range(0, 1));
            model_edge(r, iv, st, fl, op, res, ov, d, rw);
            drive(r, iv, st, fl, op, res, ov, d, rw);
            $display("rnd %0d: rst_n=%b iv=%b st=%b fl=%b op=%h res=%h ov=%b -> valid=%b res=%h rd=%h rw=%b zvn=%b%b%b",
                     c, r, iv, st, fl, op, res, ov,
                     out_valid, out_result, out_rd, out_reg_write, flag_z, flag_v, flag_n);
            chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(m_valid));
            chk($sformatf("rnd%0d out_reg_write", c), 32'(out_reg_write), 32'(m_rw));
            chk($sformatf("rnd%0d flags", c), 32'({flag_z, flag_v, flag_n}), 32'({m_z, m_v, m_n}));
            if (m_valid || !r) begin
                chk($sformatf("rnd%0d out_result", c), 32'(out_result), 32'(m_res));
                chk($sformatf("rnd%0d out_rd", c), 32'(out_rd), 32'(m_rd));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
